// File: rtl/stream_framer_pkg.sv
// stream_framer_pkg: shared types and constants for the stream framer.
package stream_framer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DONE  = 2'd2
    } FramerState;

    localparam int DROP_COUNT_WIDTH = 16;

endpackage

// File: rtl/axi4s_if.sv
// AXI4S: minimal AXI4-Stream bundle (valid/ready/data/last/keep).
interface AXI4S #(
    parameter int WIDTH = 3
) ();
    localparam int KEEP_W = (WIDTH + 7) / 8;

    logic              valid;
    logic              ready;
    logic [WIDTH-1:0]  data;
    logic              last;
    logic [KEEP_W-1:0] keep;

    modport Master (output valid, output data, output last, output keep, input ready);
    modport Slave  (input valid, input data, input last, input keep, output ready);
endinterface

// File: rtl/framer_skid_buffer.sv
// framer_skid_buffer: two-entry FIFO holding {last, data} with a
// registered push_ready and a synchronous flush that empties it.
module framer_skid_buffer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push       = push_valid & ready_q;
    assign pop        = pop_valid & pop_ready;
    assign push_ready = ready_q;
    assign pop_valid  = (count_q != 2'd0);
    assign pop_data   = mem[rd_ptr_q];

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and the registered ready; flush empties the buffer.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

    // Entry storage; contents are only meaningful while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/stream_framer.sv
// stream_framer: cuts an endless AXI4-Stream into frames of frameLength
// beats (0 means 2^LEN_WIDTH) with last on the final beat, one frame per
// arm cycle. Optional macro FRAMER_DROP_COUNT_EN adds the dropCount port,
// a saturating count of samples offered while not framing.
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int WIRE_WIDTH = 3,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 arm,
    input  logic [LEN_WIDTH-1:0] frameLength,
    output logic                 busy,
    AXI4S.Slave                  in,
    AXI4S.Master                 out
`ifdef FRAMER_DROP_COUNT_EN
    ,
    output logic [DROP_COUNT_WIDTH-1:0] dropCount
`endif
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FRAME = FRAME;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [LEN_WIDTH:0] CNT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH:0]    beat_cnt_q;
    logic [LEN_WIDTH:0]    eff_len;
    logic                  last_acc_q;
    logic                  in_ready;
    logic                  accept;
    logic                  beat_last;
    logic                  abort;
    logic                  start;

    logic                  skid_rdy;
    logic                  vld_p0;
    logic [WIRE_WIDTH:0]   beat_p0;
    logic                  out_take;

    logic                  vld_p1;
    logic [WIRE_WIDTH-1:0] data_p1;
    logic                  last_p1;

    assign eff_len   = (len_q == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, len_q};
    assign beat_last = (beat_cnt_q == (eff_len - CNT_ONE));
    assign in_ready  = (state_q == ST_FRAME) & skid_rdy & ~last_acc_q;
    assign accept    = in.valid & in_ready;
    assign abort     = (state_q == ST_FRAME) & ~arm;
    assign start     = (state_q == ST_IDLE) & arm;
    assign in.ready  = in_ready;

    // Frame sequencing: arm starts, last acceptance completes, arm low ends or aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arm) state_d = ST_FRAME;
            ST_FRAME: begin
                if (!arm)                       state_d = ST_IDLE;
                else if (accept && beat_last)   state_d = ST_DONE;
            end
            ST_DONE:  if (!arm) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, latched length and beat accounting for the current frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            last_acc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                len_q      <= frameLength;
                beat_cnt_q <= '0;
                last_acc_q <= 1'b0;
            end else if (accept && !abort) begin
                beat_cnt_q <= beat_cnt_q + CNT_ONE;
                if (beat_last) last_acc_q <= 1'b1;
            end
        end
    end

    // p0: accepted beats queue in the skid buffer, tagged with last.
    framer_skid_buffer #(
        .WIDTH (WIRE_WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (abort),
        .push_valid (accept),
        .push_data  ({beat_last, in.data}),
        .push_ready (skid_rdy),
        .pop_valid  (vld_p0),
        .pop_data   (beat_p0),
        .pop_ready  (out_take)
    );

    assign out_take = ~vld_p1 | out.ready;

    // p1: registered output stage, held while stalled, flushed on abort.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (abort) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (out_take) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                last_p1 <= beat_p0[WIRE_WIDTH];
                data_p1 <= beat_p0[WIRE_WIDTH-1:0];
            end
        end
    end

    assign out.valid = vld_p1;
    assign out.data  = data_p1;
    assign out.last  = last_p1;
    assign out.keep  = '1;
    assign busy      = (state_q == ST_FRAME) | vld_p0 | vld_p1;

`ifdef FRAMER_DROP_COUNT_EN
    logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q;

    function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(input logic [DROP_COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + {{(DROP_COUNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Count offered-but-refused samples outside a frame; cleared when a frame starts.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
        end else if (start) begin
            drop_cnt_q <= '0;
        end else if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && in.valid && !in_ready) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign dropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: table of frame scenarios plus hand-written abort,
// reset and drop-count sequences, checked against an in-order scoreboard.
module tb_stream_framer;
    localparam int WW = 8;
    localparam int LW = 3;

    typedef struct packed {
        logic [WW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [LW-1:0] len;
        logic [3:0]    pat;
        int            exp_beats;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          arm = 1'b0;
    logic [LW-1:0] frameLength = '0;
    logic          busy;

    AXI4S #(.WIDTH(WW)) in_if ();
    AXI4S #(.WIDTH(WW)) out_if ();

`ifdef FRAMER_DROP_COUNT_EN
    logic [15:0] dropCount;
`endif

    stream_framer #(
        .WIRE_WIDTH (WW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .arm         (arm),
        .frameLength (frameLength),
        .busy        (busy),
        .in          (in_if),
        .out         (out_if)
`ifdef FRAMER_DROP_COUNT_EN
        ,
        .dropCount   (dropCount)
`endif
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    beat_t         sbq[$];
    int            acc_cnt = 0;
    int            eff_len = 0;
    int            out_cnt = 0;
    int            last_cnt = 0;
    int            cyc_no = 0;
    logic [3:0]    rdy_pat = 4'b1111;
    logic [WW-1:0] next_data = '0;
    logic          prev_stall = 1'b0;
    beat_t         prev_beat;
    vec_t          vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: score handshakes visible now, advance one edge, update stimulus.
    task automatic cyc(input bit flush_edge);
        beat_t b;
        bit    took;
        took = 1'b0;
        if (prev_stall)
            check("hold_stable", {out_if.valid, out_if.data, out_if.last}, {1'b1, prev_beat});
        if (in_if.valid && in_if.ready) begin
            check("accept_within_frame", (acc_cnt < eff_len), 1);
            check("skid_not_overfilled", (sbq.size() <= 2), 1);
            b.data = in_if.data;
            b.last = (acc_cnt == eff_len - 1);
            sbq.push_back(b);
            acc_cnt++;
            took = 1'b1;
        end
        if (out_if.valid && out_if.ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                b = sbq.pop_front();
                check("out_data", out_if.data, b.data);
                check("out_last", out_if.last, b.last);
            end
            out_cnt++;
            if (out_if.last) last_cnt++;
        end
        prev_stall = out_if.valid & ~out_if.ready;
        prev_beat.data = out_if.data;
        prev_beat.last = out_if.last;
        @(posedge clk);
        #1;
        if (took) begin
            next_data = next_data + 1'b1;
            in_if.data = next_data;
        end
        if (flush_edge) begin
            sbq.delete();
            prev_stall = 1'b0;
        end
        cyc_no++;
        out_if.ready = rdy_pat[cyc_no % 4];
    endtask

    task automatic run_frame(input logic [LW-1:0] len, input logic [3:0] pat, input int exp_beats);
        eff_len = (len == 0) ? (1 << LW) : int'(len);
        acc_cnt = 0;
        out_cnt = 0;
        last_cnt = 0;
        rdy_pat = pat;
        frameLength = len;
        arm = 1'b1;
        in_if.valid = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 300 && out_cnt < exp_beats; i++) begin
            cyc(1'b0);
            if (acc_cnt == eff_len) check("in_ready_after_last", in_if.ready, 0);
        end
        check("frame_beats", out_cnt, exp_beats);
        check("frame_last_count", last_cnt, 1);
        check("scoreboard_empty", sbq.size(), 0);
        arm = 1'b0;
        in_if.valid = 1'b0;
        rdy_pat = 4'b1111;
        out_if.ready = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_if.valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{len: 3'd4, pat: 4'b1111, exp_beats: 4};
        vecs[1] = '{len: 3'd0, pat: 4'b1111, exp_beats: 8};
        vecs[2] = '{len: 3'd6, pat: 4'b1001, exp_beats: 6};
        vecs[3] = '{len: 3'd3, pat: 4'b0101, exp_beats: 3};
        vecs[4] = '{len: 3'd1, pat: 4'b1111, exp_beats: 1};
        vecs[5] = '{len: 3'd7, pat: 4'b0011, exp_beats: 7};

        in_if.valid = 1'b0;
        in_if.data = '0;
        in_if.last = 1'b0;
        in_if.keep = '1;
        out_if.ready = 1'b1;

        // Reset state
        resetn = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        check("rst_out_valid", out_if.valid, 0);
        check("rst_out_data", out_if.data, 0);
        check("rst_out_last", out_if.last, 0);
        check("rst_out_keep", &out_if.keep, 1);
        check("rst_in_ready", in_if.ready, 0);
        check("rst_busy", busy, 0);
        resetn = 1'b1;
        cyc(1'b0);

`ifdef FRAMER_DROP_COUNT_EN
        check("drop_after_reset", dropCount, 0);
        in_if.valid = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b0);
        check("drop_count_10", dropCount, 10);
        arm = 1'b1;
        cyc(1'b0);
        check("drop_clear_on_arm", dropCount, 0);
        in_if.valid = 1'b0;
        arm = 1'b0;
        cyc(1'b1);
        cyc(1'b0);
`endif

        for (int v = 0; v < 6; v++) run_frame(vecs[v].len, vecs[v].pat, vecs[v].exp_beats);

        // Abort after two accepted beats of a five-beat frame
        eff_len = 5;
        acc_cnt = 0;
        out_cnt = 0;
        last_cnt = 0;
        rdy_pat = 4'b1111;
        frameLength = 3'd5;
        arm = 1'b1;
        in_if.valid = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 50 && acc_cnt < 2; i++) cyc(1'b0);
        check("abort_reached_two", acc_cnt, 2);
        arm = 1'b0;
        cyc(1'b1);
        check("abort_out_valid", out_if.valid, 0);
        check("abort_in_ready", in_if.ready, 0);
        check("abort_busy", busy, 0);
        in_if.valid = 1'b0;
        cyc(1'b0);
        check("abort_stays_empty", out_if.valid, 0);
        check("abort_no_last", last_cnt, 0);
        run_frame(3'd5, 4'b1111, 5);

        // Reset asserted for one cycle in the middle of a frame
        eff_len = 6;
        acc_cnt = 0;
        frameLength = 3'd6;
        arm = 1'b1;
        in_if.valid = 1'b1;
        rdy_pat = 4'b0101;
        cyc(1'b0);
        for (int i = 0; i < 50 && acc_cnt < 3; i++) cyc(1'b0);
        resetn = 1'b0;
        cyc(1'b1);
        check("midrst_out_valid", out_if.valid, 0);
        check("midrst_out_data", out_if.data, 0);
        check("midrst_out_last", out_if.last, 0);
        check("midrst_in_ready", in_if.ready, 0);
        check("midrst_busy", busy, 0);
        resetn = 1'b1;
        arm = 1'b0;
        in_if.valid = 1'b0;
        rdy_pat = 4'b1111;
        cyc(1'b0);
        run_frame(3'd2, 4'b1111, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_framer.md
# stream_framer

Upstream framing stage for the recorder/player path. It takes a raw AXI4-Stream sample source that never asserts `last` and emits packets of exactly `frameLength` beats, with `last` on the final beat. Capture is gated by `arm`, so the downstream recorder receives one bounded frame per arm cycle. A two-entry skid buffer keeps `in.ready` fully registered.

## Interface
Parameters:
- WIRE_WIDTH, 3, data width of `in` and `out`.
- LEN_WIDTH, 8, width of `frameLength`; maximum frame is 2^LEN_WIDTH beats.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  reset, synchronous, active-low.
- arm  input  1  level; high requests one frame, low returns to idle.
- frameLength  input  LEN_WIDTH  beats per frame; 0 encodes 2^LEN_WIDTH. Sampled on the IDLE->FRAME transition.
- busy  output  1  high in FRAME or while the skid buffer or output register holds data.
- in  AXI4S.Slave  WIRE_WIDTH  sample source; `in.last` and `in.keep` are ignored.
- out  AXI4S.Master  WIRE_WIDTH  framed stream; `out.keep` is constant all-ones.
- dropCount  output  16  present only with FRAMER_DROP_COUNT_EN.

## Operation
- FSM states, 2-bit: IDLE, FRAME, DONE.
  - IDLE->FRAME when `arm`=1. Latches `frameLength` into `lenReg` and clears `beatCnt`.
  - FRAME->DONE on acceptance of beat `lenReg`-1.
  - FRAME->IDLE when `arm`=0 (abort).
  - DONE->IDLE when `arm`=0.
  - Any other encoding goes to IDLE.
- `beatCnt` is LEN_WIDTH+1 bits and increments on each accepted input beat (`in.valid & in.ready`). The accepted beat is tagged last when `beatCnt` == effective length - 1, where effective length is `lenReg`, or 2^LEN_WIDTH when `lenReg`=0.
- `in.ready` = (state==FRAME) & skid not full & ~lastAccepted.
  - It is never high in IDLE or DONE.
  - Once the last beat is accepted, no further input beat is taken in that frame.
- Output path:
  - The skid buffer feeds a registered `out.valid`/`out.data`/`out.last`.
  - The data/last pair is held stable while `out.valid & ~out.ready`.
  - Beats leave in acceptance order with no loss or duplication.
- Frame completion: after the last beat is accepted the FSM sits in DONE. Queued beats continue to drain in DONE and in the IDLE that follows.
- Abort (`arm` low in FRAME):
  - The skid buffer and output register are flushed in the same edge that enters IDLE.
  - `out.valid` is 0 the next cycle; no `last` is emitted for the truncated frame.
- Reset values: `out.valid`=0, `out.data`=0, `out.last`=0, `out.keep`=all-ones, `in.ready`=0, `busy`=0, state=IDLE, `beatCnt`=0, skid empty, `dropCount`=0.
- Reset mid-frame behaves exactly like reset from idle.

## Timing
- Latency: an input beat accepted at edge n is visible on `out` after edge n+1 when the path is empty.
- Throughput: 1 beat/cycle sustained when `out.ready`=1.
- `in.ready` is a register output; it depends on no combinational path from `out.ready`.
- `arm` high at edge n: state=FRAME after edge n, so `in.ready` can be 1 in cycle n+1.
- Simultaneous `arm` falling and last-beat acceptance: abort takes priority; state goes to IDLE and the path is flushed.
- Back-to-back frames: DONE requires `arm`=0 for at least one cycle before the next frame starts.

## Configuration
- FRAMER_DROP_COUNT_EN defined:
  - `dropCount` port exists.
  - It is a saturating 16-bit count of cycles with `in.valid`=1 and `in.ready`=0 while state is IDLE or DONE.
  - It clears on reset and on the IDLE->FRAME transition.
  - It holds at 16'hFFFF.
- Not defined: no port and no counter logic. Behaviour is otherwise identical.

## Structure
- Package `stream_framer_pkg`:
  - `FramerState` enum (IDLE, FRAME, DONE).
  - `DROP_COUNT_WIDTH`=16.
- Sub-module `framer_skid_buffer`:
  - Two-entry data+last buffer with a registered ready.
  - Parameter WIRE_WIDTH+1, plus a synchronous flush input.

## Test plan
- Frame of 4: `frameLength`=4, `arm`=1, continuous `in.valid` with data 0,1,2,3,4…, `out.ready`=1. Expect `out` = 0,1,2,3 with `last` only on 3. `in.ready` drops after the 4th acceptance; state DONE.
- Length 0: LEN_WIDTH=3, `frameLength`=0. Expect exactly 8 beats out with `last` on the 8th.
- Backpressure: `out.ready` toggles 1,0,0,1 for 20 cycles on a 6-beat frame. Expect data held stable while stalled, no loss or duplication, and `in.ready` low while the skid buffer is full.
- Abort: `arm` falls after 2 of 5 beats accepted. Expect `out.valid`=0 one cycle later, no `last`, state IDLE. Re-arming yields a fresh 5-beat frame starting at `beatCnt`=0.
- Reset: `resetn`=0 mid-frame for 1 cycle. Expect all outputs at reset values next cycle and `busy`=0.
- FRAMER_DROP_COUNT_EN: `in.valid`=1 for 10 cycles in IDLE. Expect `dropCount`=10; it clears to 0 on the next arm.
